// File: rtl/datapath_pkg.sv
// Shared types for the datapath FIFO arbiter: FSM encodings and default beat width.
package datapath_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH = 128;

  typedef enum logic [1:0] {WIdle, WBeat0, WBeat1} w_state_t;
  typedef enum logic [1:0] {RIdle, RDrain, RFlush} r_state_t;

endpackage

// File: rtl/datapath_rd_sequencer.sv
// Read-side sequencer: raises the FIFO read request on threshold or flush and
// counts the words actually read.
module datapath_rd_sequencer
  import datapath_pkg::*;
#(
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 flush_req,
  input  logic                 fifo_empty,
  input  logic                 fifo_threshold,
  input  logic                 fifo_rd_pulse,
  input  logic                 clr,
  output logic                 fifo_rd,
  output logic                 flush_done,
  output logic [CNT_WIDTH-1:0] words_read
);

  r_state_t             r_state_q, r_state_d;
  logic                 flush_pend_q, flush_pend_d;
  logic                 pend_clr;
  logic [CNT_WIDTH-1:0] words_q;

  always_comb begin
    r_state_d  = r_state_q;
    pend_clr   = 1'b0;
    flush_done = 1'b0;
    unique case (r_state_q)
      RIdle: begin
        if (flush_pend_q && fifo_empty) begin
          flush_done = 1'b1;
          pend_clr   = 1'b1;
        end else if (enable && flush_pend_q) begin
          r_state_d = RFlush;
        end else if (enable && fifo_threshold) begin
          r_state_d = RDrain;
        end
      end
      RDrain: begin
        if (!enable || fifo_empty) r_state_d = RIdle;
        else if (flush_pend_q)     r_state_d = RFlush;
      end
      RFlush: begin
        // A flush interrupted by !enable stays pending and resumes later.
        if (fifo_empty) begin
          r_state_d  = RIdle;
          flush_done = 1'b1;
          pend_clr   = 1'b1;
        end else if (!enable) begin
          r_state_d = RIdle;
        end
      end
      default: r_state_d = RIdle;
    endcase
    flush_pend_d = flush_req ? 1'b1 : (pend_clr ? 1'b0 : flush_pend_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state_q    <= RIdle;
      flush_pend_q <= 1'b0;
      words_q      <= '0;
    end else begin
      r_state_q    <= r_state_d;
      flush_pend_q <= flush_pend_d;
      if (clr)                words_q <= '0;
      else if (fifo_rd_pulse) words_q <= words_q + 1'b1;
    end
  end

  assign fifo_rd    = (r_state_q != RIdle);
  assign words_read = words_q;

endmodule

// File: rtl/datapath_fifo_arbiter.sv
// Two-source pair arbiter for the datapath FIFO write port plus read-side sequencing.
// Pairs are atomic so the FIFO's beat toggle never sees interleaved sources.
module datapath_fifo_arbiter
  import datapath_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int unsigned STALL_MAX  = 64,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  src0_valid,
  input  logic [DATA_WIDTH-1:0] src0_data,
  output logic                  src0_ready,
  input  logic                  src1_valid,
  input  logic [DATA_WIDTH-1:0] src1_data,
  output logic                  src1_ready,
  output logic                  fifo_wr,
  output logic [DATA_WIDTH-1:0] fifo_data,
  input  logic                  fifo_full,
  input  logic                  fifo_empty,
  input  logic                  fifo_threshold,
  input  logic                  fifo_rd_pulse,
  output logic                  fifo_rd,
  input  logic                  enable,
  input  logic                  flush_req,
  output logic                  flush_done,
  input  logic                  clr,
  output logic [CNT_WIDTH-1:0]  pairs0,
  output logic [CNT_WIDTH-1:0]  pairs1,
  output logic [CNT_WIDTH-1:0]  words_read,
  output logic                  stall_err
);

  localparam int unsigned StallW = $clog2(STALL_MAX + 1);

  w_state_t             w_state_q, w_state_d;
  logic                 gnt_q, gnt_d;
  logic                 last_q, last_d;
  logic [StallW-1:0]    stall_cnt_q, stall_cnt_d;
  logic                 stall_err_q;
  logic [CNT_WIDTH-1:0] pairs0_q, pairs1_q;
  logic                 in_pair, gnt_valid, xfer, pair_done, stall, stall_set;

  always_comb begin
    w_state_d  = w_state_q;
    gnt_d      = gnt_q;
    last_d     = last_q;
    in_pair    = (w_state_q != WIdle);
    gnt_valid  = gnt_q ? src1_valid : src0_valid;
    xfer       = in_pair && gnt_valid;
    pair_done  = xfer && (w_state_q == WBeat1);
    stall      = in_pair && !gnt_valid;
    src0_ready = in_pair && !gnt_q;
    src1_ready = in_pair && gnt_q;
    fifo_wr    = xfer;
    fifo_data  = '0;
    if (xfer) fifo_data = gnt_q ? src1_data : src0_data;

    unique case (w_state_q)
      WIdle: begin
        if (!fifo_full && (src0_valid || src1_valid)) begin
          gnt_d     = (src0_valid && src1_valid) ? !last_q : src1_valid;
          w_state_d = WBeat0;
        end
      end
      WBeat0: if (xfer) w_state_d = WBeat1;
      WBeat1: begin
        if (xfer) begin
          w_state_d = WIdle;
          last_d    = gnt_q;
        end
      end
      default: w_state_d = WIdle;
    endcase

    // Counter saturates so the sticky flag cannot be re-armed by wrap-around.
    stall_cnt_d = stall_cnt_q;
    if (!in_pair || xfer)                               stall_cnt_d = '0;
    else if (stall_cnt_q != StallW'(STALL_MAX))         stall_cnt_d = stall_cnt_q + 1'b1;
    stall_set = stall && (stall_cnt_q == StallW'(STALL_MAX - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_state_q   <= WIdle;
      gnt_q       <= 1'b0;
      last_q      <= 1'b1;
      stall_cnt_q <= '0;
      stall_err_q <= 1'b0;
      pairs0_q    <= '0;
      pairs1_q    <= '0;
    end else begin
      w_state_q   <= w_state_d;
      gnt_q       <= gnt_d;
      last_q      <= last_d;
      stall_cnt_q <= stall_cnt_d;
      if (clr)            stall_err_q <= 1'b0;
      else if (stall_set) stall_err_q <= 1'b1;
      if (clr)                      pairs0_q <= '0;
      else if (pair_done && !gnt_q) pairs0_q <= pairs0_q + 1'b1;
      if (clr)                      pairs1_q <= '0;
      else if (pair_done && gnt_q)  pairs1_q <= pairs1_q + 1'b1;
    end
  end

  assign pairs0    = pairs0_q;
  assign pairs1    = pairs1_q;
  assign stall_err = stall_err_q;

  datapath_rd_sequencer #(
    .CNT_WIDTH (CNT_WIDTH)
  ) u_rd_seq (
    .clk            (clk),
    .rst            (rst),
    .enable         (enable),
    .flush_req      (flush_req),
    .fifo_empty     (fifo_empty),
    .fifo_threshold (fifo_threshold),
    .fifo_rd_pulse  (fifo_rd_pulse),
    .clr            (clr),
    .fifo_rd        (fifo_rd),
    .flush_done     (flush_done),
    .words_read     (words_read)
  );

endmodule

// File: tb/tb_datapath_fifo_arbiter.sv
// Directed bench for datapath_fifo_arbiter: vector table for arbitration and
// full gating, hand sequences for stall, drain, flush and async reset.
module tb_datapath_fifo_arbiter;

  localparam int unsigned DW = 128;
  localparam int unsigned SM = 64;
  localparam int unsigned CW = 16;

  logic          clk, rst;
  logic          src0_valid, src1_valid, src0_ready, src1_ready;
  logic [DW-1:0] src0_data, src1_data, fifo_data;
  logic          fifo_wr, fifo_full, fifo_empty, fifo_threshold, fifo_rd_pulse, fifo_rd;
  logic          enable, flush_req, flush_done, clr, stall_err;
  logic [CW-1:0] pairs0, pairs1, words_read;

  int checks = 0;
  int failures = 0;

  datapath_fifo_arbiter #(
    .DATA_WIDTH (DW),
    .STALL_MAX  (SM),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .src0_valid     (src0_valid),
    .src0_data      (src0_data),
    .src0_ready     (src0_ready),
    .src1_valid     (src1_valid),
    .src1_data      (src1_data),
    .src1_ready     (src1_ready),
    .fifo_wr        (fifo_wr),
    .fifo_data      (fifo_data),
    .fifo_full      (fifo_full),
    .fifo_empty     (fifo_empty),
    .fifo_threshold (fifo_threshold),
    .fifo_rd_pulse  (fifo_rd_pulse),
    .fifo_rd        (fifo_rd),
    .enable         (enable),
    .flush_req      (flush_req),
    .flush_done     (flush_done),
    .clr            (clr),
    .pairs0         (pairs0),
    .pairs1         (pairs1),
    .words_read     (words_read),
    .stall_err      (stall_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v0, v1, full;
    logic        r0, r1, wr;
    logic [31:0] data;
    logic [15:0] p0, p1;
  } vec_t;

  vec_t vecs [16];

  function automatic vec_t mk(input logic v0, input logic v1, input logic full,
                              input logic r0, input logic r1, input logic wr,
                              input logic [31:0] data, input logic [15:0] p0,
                              input logic [15:0] p1);
    vec_t v;
    v.v0 = v0; v.v1 = v1; v.full = full;
    v.r0 = r0; v.r1 = r1; v.wr = wr; v.data = data; v.p0 = p0; v.p1 = p1;
    return v;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Each row: one cycle; data on srcN is 0x1000+i / 0x2000+i for row i.
    vecs[0]  = mk(1, 1, 0,  0, 0, 0, 32'h0,    0, 0);
    vecs[1]  = mk(1, 1, 0,  1, 0, 1, 32'h1001, 0, 0);
    vecs[2]  = mk(1, 1, 0,  1, 0, 1, 32'h1002, 0, 0);
    vecs[3]  = mk(1, 1, 0,  0, 0, 0, 32'h0,    1, 0);
    vecs[4]  = mk(1, 1, 0,  0, 1, 1, 32'h2004, 1, 0);
    vecs[5]  = mk(1, 1, 0,  0, 1, 1, 32'h2005, 1, 0);
    vecs[6]  = mk(1, 1, 0,  0, 0, 0, 32'h0,    1, 1);
    vecs[7]  = mk(1, 1, 0,  1, 0, 1, 32'h1007, 1, 1);
    vecs[8]  = mk(1, 1, 0,  1, 0, 1, 32'h1008, 1, 1);
    vecs[9]  = mk(0, 0, 0,  0, 0, 0, 32'h0,    2, 1);
    vecs[10] = mk(1, 0, 1,  0, 0, 0, 32'h0,    2, 1);
    vecs[11] = mk(1, 0, 1,  0, 0, 0, 32'h0,    2, 1);
    vecs[12] = mk(1, 0, 0,  0, 0, 0, 32'h0,    2, 1);
    vecs[13] = mk(1, 0, 0,  1, 0, 1, 32'h100d, 2, 1);
    vecs[14] = mk(1, 0, 1,  1, 0, 1, 32'h100e, 2, 1);
    vecs[15] = mk(0, 0, 0,  0, 0, 0, 32'h0,    3, 1);

    rst = 1'b1;
    src0_valid = 0; src1_valid = 0; src0_data = '0; src1_data = '0;
    fifo_full = 0; fifo_empty = 1; fifo_threshold = 0; fifo_rd_pulse = 0;
    enable = 0; flush_req = 0; clr = 0;
    #1;
    chk("reset fifo_wr", 128'(fifo_wr), 0);
    chk("reset fifo_rd", 128'(fifo_rd), 0);
    chk("reset ready", 128'({src0_ready, src1_ready}), 0);
    chk("reset fifo_data", fifo_data, 0);
    chk("reset stall_err", 128'(stall_err), 0);
    @(negedge clk);
    rst = 1'b0;
    step();

    for (int i = 0; i < 16; i++) begin
      src0_valid = vecs[i].v0;
      src1_valid = vecs[i].v1;
      fifo_full  = vecs[i].full;
      src0_data  = 128'(32'(32'h1000 + i));
      src1_data  = 128'(32'(32'h2000 + i));
      #1;
      chk($sformatf("vec%0d src0_ready", i), 128'(src0_ready), 128'(vecs[i].r0));
      chk($sformatf("vec%0d src1_ready", i), 128'(src1_ready), 128'(vecs[i].r1));
      chk($sformatf("vec%0d fifo_wr", i), 128'(fifo_wr), 128'(vecs[i].wr));
      chk($sformatf("vec%0d fifo_data", i), fifo_data, 128'(vecs[i].data));
      chk($sformatf("vec%0d pairs0", i), 128'(pairs0), 128'(vecs[i].p0));
      chk($sformatf("vec%0d pairs1", i), 128'(pairs1), 128'(vecs[i].p1));
      step();
    end

    // Stall inside a src1 pair.
    src1_valid = 1; src1_data = 128'h5a;
    step();
    #1;
    chk("stall beat0 wr", 128'(fifo_wr), 1);
    chk("stall beat0 data", fifo_data, 128'h5a);
    step();
    src1_valid = 0;
    for (int i = 0; i < SM - 1; i++) step();
    chk("stall before max", 128'(stall_err), 0);
    chk("stall ready held", 128'(src1_ready), 1);
    step();
    chk("stall at max", 128'(stall_err), 1);
    for (int i = 0; i < 3; i++) step();
    chk("stall sticky", 128'(stall_err), 1);
    src1_valid = 1; src1_data = 128'ha5;
    #1;
    chk("stall beat1 data", fifo_data, 128'ha5);
    step();
    src1_valid = 0;
    chk("stall pairs1", 128'(pairs1), 2);
    clr = 1;
    step();
    clr = 0;
    chk("clr stall_err", 128'(stall_err), 0);
    chk("clr pairs", 128'({pairs0, pairs1}), 0);

    // Threshold drain.
    enable = 1; fifo_empty = 0; fifo_threshold = 1;
    #1;
    chk("drain rd before", 128'(fifo_rd), 0);
    step();
    chk("drain rd on", 128'(fifo_rd), 1);
    fifo_threshold = 0; fifo_rd_pulse = 1;
    for (int i = 0; i < 5; i++) step();
    fifo_rd_pulse = 0; fifo_empty = 1;
    #1;
    chk("drain words", 128'(words_read), 5);
    step();
    chk("drain rd off", 128'(fifo_rd), 0);

    // Flush requested while disabled with three words held.
    enable = 0; fifo_empty = 0; flush_req = 1;
    step();
    flush_req = 0;
    #1;
    chk("flush disabled rd", 128'(fifo_rd), 0);
    chk("flush disabled done", 128'(flush_done), 0);
    step();
    chk("flush disabled rd2", 128'(fifo_rd), 0);
    enable = 1;
    step();
    chk("flush rd on", 128'(fifo_rd), 1);
    chk("flush no early done", 128'(flush_done), 0);
    fifo_rd_pulse = 1;
    for (int i = 0; i < 3; i++) step();
    fifo_rd_pulse = 0; fifo_empty = 1;
    #1;
    chk("flush done pulse", 128'(flush_done), 1);
    chk("flush words", 128'(words_read), 8);
    step();
    chk("flush done one cycle", 128'(flush_done), 0);
    chk("flush rd off", 128'(fifo_rd), 0);

    flush_req = 1;
    step();
    flush_req = 0;
    #1;
    chk("empty flush done", 128'(flush_done), 1);
    step();
    chk("empty flush done once", 128'(flush_done), 0);

    // Reach W_BEAT1 (src1) and R_FLUSH, then reset asynchronously.
    fifo_empty = 0; flush_req = 1; src0_valid = 1; src1_valid = 0;
    src0_data = 128'h77; src1_data = 128'h88;
    step();
    flush_req = 0;
    step();
    step();
    src1_valid = 1;
    step();
    step();
    #1;
    chk("pre-rst src1_ready", 128'(src1_ready), 1);
    chk("pre-rst fifo_data", fifo_data, 128'h88);
    chk("pre-rst fifo_rd", 128'(fifo_rd), 1);
    #2;
    rst = 1;
    #1;
    chk("rst fifo_wr", 128'(fifo_wr), 0);
    chk("rst ready", 128'({src0_ready, src1_ready}), 0);
    chk("rst fifo_data", fifo_data, 0);
    chk("rst fifo_rd", 128'(fifo_rd), 0);
    chk("rst counters", 128'({pairs0, pairs1, words_read}), 0);
    chk("rst flush_done", 128'(flush_done), 0);
    @(negedge clk);
    rst = 0;
    step();
    chk("post-rst src0 grant", 128'(src0_ready), 1);
    chk("post-rst src1 idle", 128'(src1_ready), 0);
    chk("post-rst data", fifo_data, 128'h77);
    chk("post-rst fifo_rd", 128'(fifo_rd), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
